// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO frame controller: state encoding and default sizes.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 3;

endpackage

// File: rtl/sipo_shift_reg.sv
// Shift datapath: MSB-first serial-in, parallel-out register.
module sipo_shift_reg #(
  parameter int WIDTH = sipo_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // clr outranks shift_en so an abort/restart never samples that cycle's bit
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: start opens a frame, WIDTH qualified bits are shifted in,
// then the word is held and offered on a valid/ready handshake.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             sreg_clr;
  logic             sreg_shift;
  logic             last_bit;

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // Datapath controls decoded from the current state; start always wins over din_valid
  always_comb begin
    sreg_clr   = 1'b0;
    sreg_shift = 1'b0;
    case (state)
      ST_IDLE:  sreg_clr = start;
      ST_SHIFT: begin
        sreg_clr   = start;
        sreg_shift = !start && din_valid;
      end
      ST_HOLD:  sreg_clr = q_ready && start;
      default: begin
        sreg_clr   = 1'b0;
        sreg_shift = 1'b0;
      end
    endcase
  end

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .clr     (sreg_clr),
    .shift_en(sreg_shift),
    .din     (din),
    .q       (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            count <= '0;
          end
        end
        ST_SHIFT: begin
          if (start) begin
            count <= '0;
          end else if (din_valid) begin
            count <= count + CNT_W'(1);
            if (last_bit) begin
              state   <= ST_HOLD;
              q_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Bits arriving while a word is parked are dropped and flagged until reset
          if (din_valid) begin
            overrun <= 1'b1;
          end
          if (q_ready) begin
            q_valid <= 1'b0;
            count   <= '0;
            state   <= start ? ST_SHIFT : ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          count   <= '0;
          q_valid <= 1'b0;
        end
      endcase
    end
  end

  assign qbar = ~q;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl with WIDTH=4 and a 100 ns clock.
module tb_sipo_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       din;
  logic       din_valid;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       q_valid;
  logic       q_ready;
  logic       busy;
  logic       overrun;

  int testsRun;
  int testsFailed;

  sipo_frame_ctrl #(
    .WIDTH(4),
    .CNT_W(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
    .din_valid(din_valid),
    .q        (q),
    .qbar     (qbar),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Drive one cycle's inputs, then let the edge pass and settle before checking
  task automatic applyStimulus(input logic r, input logic s, input logic d,
                               input logic dv, input logic qr);
    rst       = r;
    start     = s;
    din       = d;
    din_valid = dv;
    q_ready   = qr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shiftBit(input logic d);
    applyStimulus(1'b0, 1'b0, d, 1'b1, 1'b0);
  endtask

  task automatic stallCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic checkWord(input string tag, input logic [3:0] expQ, input logic expValid,
                           input logic expBusy);
    checkOutput({tag, ".q"}, {4'h0, q}, {4'h0, expQ});
    checkOutput({tag, ".qbar"}, {4'h0, qbar}, {4'h0, ~expQ});
    checkOutput({tag, ".q_valid"}, {7'h0, q_valid}, {7'h0, expValid});
    checkOutput({tag, ".busy"}, {7'h0, busy}, {7'h0, expBusy});
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; q_ready = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    checkWord("reset", 4'b0000, 1'b0, 1'b0);
    checkOutput("reset.overrun", {7'h0, overrun}, 8'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkWord("idle_ignore_din", 4'b0000, 1'b0, 1'b0);

    // 2: basic frame 1,0,1,1 with start-cycle din ignored and a held handshake
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkWord("f2.start", 4'b0000, 1'b0, 1'b1);
    shiftBit(1'b1);
    shiftBit(1'b0);
    shiftBit(1'b1);
    checkWord("f2.bit3", 4'b0101, 1'b0, 1'b1);
    shiftBit(1'b1);
    checkWord("f2.done", 4'b1011, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkWord("f2.hold", 4'b1011, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkWord("f2.accept", 4'b1011, 1'b0, 1'b0);

    // 3: stalls between valid bits
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftBit(1'b1); stallCycle();
    shiftBit(1'b0); stallCycle();
    shiftBit(1'b0); stallCycle();
    checkWord("f3.stall", 4'b0100, 1'b0, 1'b1);
    shiftBit(1'b1);
    checkWord("f3.done", 4'b1001, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: restart mid-frame discards the partial word
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftBit(1'b1);
    shiftBit(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkWord("f4.restart", 4'b0000, 1'b0, 1'b1);
    shiftBit(1'b0);
    shiftBit(1'b1);
    shiftBit(1'b0);
    checkWord("f4.bit3", 4'b0010, 1'b0, 1'b1);
    shiftBit(1'b1);
    checkWord("f4.done", 4'b0101, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: overrun in HOLD, ignored start, back-to-back handshake into SHIFT
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftBit(1'b1); shiftBit(1'b1); shiftBit(1'b0); shiftBit(1'b0);
    checkOutput("f5.no_overrun", {7'h0, overrun}, 8'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkWord("f5.overrun_q", 4'b1100, 1'b1, 1'b1);
    checkOutput("f5.overrun", {7'h0, overrun}, 8'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkWord("f5.start_ignored", 4'b1100, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkWord("f5.direct_shift", 4'b0000, 1'b0, 1'b1);
    shiftBit(1'b0); shiftBit(1'b1); shiftBit(1'b1); shiftBit(1'b0);
    checkWord("f5.second", 4'b0110, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkWord("f5.accept", 4'b0110, 1'b0, 1'b0);
    checkOutput("f5.sticky", {7'h0, overrun}, 8'h1);

    // 6: reset mid-SHIFT clears everything including the bit counter
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftBit(1'b1);
    shiftBit(1'b1);
    checkWord("f6.partial", 4'b0011, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkWord("f6.reset", 4'b0000, 1'b0, 1'b0);
    checkOutput("f6.overrun_clr", {7'h0, overrun}, 8'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftBit(1'b1); shiftBit(1'b0); shiftBit(1'b0);
    checkWord("f6.count_cleared", 4'b0100, 1'b0, 1'b1);
    shiftBit(1'b0);
    checkWord("f6.done", 4'b1000, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
